// File: rtl/fme_cand_decision_pkg.sv
// Shared constants, FSM state type and candidate geometry tables for FME candidate decision.
package fme_cand_decision_pkg;

  localparam int unsigned NUM_CAND = 9;
  localparam int unsigned SUBBLK   = 4;
  localparam int unsigned SATD_W   = 16;
  localparam int unsigned LAMBDA_W = 8;
  localparam int unsigned COST_W   = 20;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned MV_W     = 3;
  localparam int unsigned SUB_W    = (SUBBLK > 1) ? $clog2(SUBBLK) : 1;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  // Fractional x offset of a candidate; 0 is the centre.
  function automatic logic signed [1:0] cand_dx(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd6: cand_dx = -2'sd1;
      4'd3, 4'd5, 4'd8: cand_dx = 2'sd1;
      default:          cand_dx = 2'sd0;
    endcase
  endfunction

  // Fractional y offset of a candidate.
  function automatic logic signed [1:0] cand_dy(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd1, 4'd2, 4'd3: cand_dy = -2'sd1;
      4'd6, 4'd7, 4'd8: cand_dy = 2'sd1;
      default:          cand_dy = 2'sd0;
    endcase
  endfunction

  // Estimated MV bits: centre 1, orthogonal 3, diagonal 7.
  function automatic logic [MV_W-1:0] mv_bits(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:                   mv_bits = 3'd1;
      4'd2, 4'd4, 4'd5, 4'd7: mv_bits = 3'd3;
      default:                mv_bits = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/fme_cand_decision_if.sv
// SATD input stream and best-candidate result port of the FME candidate decision block.
interface fme_cand_decision_if;
  import fme_cand_decision_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [SATD_W-1:0]       in_satd;
  logic                    out_valid;
  logic                    out_ready;
  logic [IDX_W-1:0]        best_idx;
  logic signed [1:0]       best_dx;
  logic signed [1:0]       best_dy;
  logic [COST_W-1:0]       best_cost;

  // Decision block side.
  modport slave (
    input  in_valid, in_satd, out_ready,
    output in_ready, out_valid, best_idx, best_dx, best_dy, best_cost
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_satd, out_ready,
    input  in_ready, out_valid, best_idx, best_dx, best_dy, best_cost
  );

endinterface

// File: rtl/fme_cand_decision_mv_cost.sv
// Lambda-weighted MV rate cost, built as a shift-add over the set bits of the MV-bit count.
module fme_cand_decision_mv_cost
  import fme_cand_decision_pkg::*;
(
  input  logic [LAMBDA_W-1:0] lambda_i,
  input  logic [MV_W-1:0]     mv_bits_i,
  output logic [COST_W-1:0]   cost_o
);

  // One shifted copy of lambda per set bit of mv_bits.
  always_comb begin
    cost_o = '0;
    for (int i = 0; i < int'(MV_W); i++) begin
      if (mv_bits_i[i]) begin
        cost_o = cost_o + (COST_W'(lambda_i) << i);
      end
    end
  end

endmodule

// File: rtl/fme_cand_decision.sv
// Accumulates per-candidate SATD sums plus MV rate cost and keeps the cheapest candidate.
module fme_cand_decision
  import fme_cand_decision_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flush,
  input  logic [LAMBDA_W-1:0] lambda,
  fme_cand_decision_if.slave  bus
);

  state_e               state_q, state_d;
  logic [SUB_W-1:0]     sub_q, sub_d;
  logic [IDX_W-1:0]     cand_q, cand_d;
  logic [COST_W-1:0]    acc_q, acc_d;
  logic [LAMBDA_W-1:0]  lambda_q, lambda_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic signed [1:0]    best_dx_q, best_dx_d;
  logic signed [1:0]    best_dy_q, best_dy_d;
  logic [COST_W-1:0]    best_cost_q, best_cost_d;

  logic                 accept;
  logic                 last_sub;
  logic                 last_cand;
  logic [COST_W-1:0]    sum;
  logic [COST_W-1:0]    total;
  logic [COST_W-1:0]    mv_cost;

  fme_cand_decision_mv_cost u_mv_cost (
    .lambda_i  (lambda_q),
    .mv_bits_i (mv_bits(cand_q)),
    .cost_o    (mv_cost)
  );

  assign accept    = bus.in_valid && (state_q == StAcc);
  assign last_sub  = (sub_q == SUB_W'(SUBBLK - 1));
  assign last_cand = (cand_q == IDX_W'(NUM_CAND - 1));
  // The first sub of a candidate restarts the sum instead of adding to the stale one.
  assign sum       = ((sub_q == '0) ? '0 : acc_q) + COST_W'(bus.in_satd);
  assign total     = sum + mv_cost;

  // Next-state, counters, accumulator and best-candidate tracking.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    cand_d      = cand_q;
    acc_d       = acc_q;
    lambda_d    = lambda_q;
    best_idx_d  = best_idx_q;
    best_dx_d   = best_dx_q;
    best_dy_d   = best_dy_q;
    best_cost_d = best_cost_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StAcc;
          lambda_d = lambda;
          sub_d    = '0;
          cand_d   = '0;
          acc_d    = '0;
        end
      end
      StAcc: begin
        if (accept) begin
          if (last_sub) begin
            sub_d  = '0;
            cand_d = cand_q + IDX_W'(1);
            // Strict less-than: ties keep the lower index, so the centre wins ties.
            if ((cand_q == '0) || (total < best_cost_q)) begin
              best_idx_d  = cand_q;
              best_dx_d   = cand_dx(cand_q);
              best_dy_d   = cand_dy(cand_q);
              best_cost_d = total;
            end
            if (last_cand) begin
              state_d = StDone;
              cand_d  = '0;
            end
          end else begin
            acc_d = sum;
            sub_d = sub_q + SUB_W'(1);
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over every transition; best outputs are left untouched.
    if (flush) begin
      state_d = StIdle;
      sub_d   = '0;
      cand_d  = '0;
      acc_d   = '0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sub_q       <= '0;
      cand_q      <= '0;
      acc_q       <= '0;
      lambda_q    <= '0;
      best_idx_q  <= '0;
      best_dx_q   <= '0;
      best_dy_q   <= '0;
      best_cost_q <= '0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      cand_q      <= cand_d;
      acc_q       <= acc_d;
      lambda_q    <= lambda_d;
      best_idx_q  <= best_idx_d;
      best_dx_q   <= best_dx_d;
      best_dy_q   <= best_dy_d;
      best_cost_q <= best_cost_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StDone);
  assign bus.best_idx  = best_idx_q;
  assign bus.best_dx   = best_dx_q;
  assign bus.best_dy   = best_dy_q;
  assign bus.best_cost = best_cost_q;

endmodule
